// File: rtl/sms_reset_sequencer.sv
// sms_reset_sequencer: staggered active-low card reset generator.
// After a hold period, channel a[0] releases first and each following
// channel releases a fixed number of clocks later. A manual reset key
// (trig_n) restarts the whole sequence from the hold period.
// Optional build macro SEQ_DEBOUNCE_EN: when it is defined, trig_n must be
// low for DEBOUNCE_CYCLES consecutive clocks before it takes effect.
`timescale 1ns/1ps
module sms_reset_sequencer #(
  parameter int NUM_CH          = 4,
  parameter int HOLD_CYCLES     = 100,
  parameter int STAGGER_CYCLES  = 10,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_n,
  output logic [NUM_CH-1:0] a,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // The counter must be able to hold every configured period.
  if (longint'(HOLD_CYCLES) > longint'(CNT_MAX) ||
      longint'(STAGGER_CYCLES) > longint'(CNT_MAX) ||
      longint'(DEBOUNCE_CYCLES) > longint'(CNT_MAX)) begin : g_cnt_w_too_small
    $error("sms_reset_sequencer: CNT_W too small for configured cycle counts");
  end

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              sync1_reg;
  logic              trig_s;
  logic              force_req;
  logic [NUM_CH-1:0] rel_mask;

  // Two-flop synchronizer for the asynchronous manual reset key.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      trig_s    <= 1'b1;
    end else begin
      sync1_reg <= trig_n;
      trig_s    <= sync1_reg;
    end
  end

`ifdef SEQ_DEBOUNCE_EN
  logic [CNT_W-1:0] deb_cnt_reg;

  // Count consecutive low samples of trig_s; any high sample clears it.
  always_ff @(posedge clk) begin
    if (rst || trig_s) begin
      deb_cnt_reg <= '0;
    end else if (deb_cnt_reg < CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_cnt_reg <= deb_cnt_reg + CNT_W'(1);
    end
  end

  // The request takes effect on the DEBOUNCE_CYCLES-th consecutive low sample
  // and stays in effect while trig_s remains low; release is immediate.
  assign force_req = ~trig_s & (deb_cnt_reg >= CNT_W'(DEBOUNCE_CYCLES - 1));
`else
  // Any single low sample of the synchronized key is a restart request.
  assign force_req = ~trig_s;
`endif

  // One-hot mask selecting the channel addressed by the stagger index.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rel_mask
    assign rel_mask[gi] = (idx_reg == IDX_W'(gi));
  end

  // Sequencing FSM: hold all channels, then release them one by one.
  always_ff @(posedge clk) begin
    if (rst || force_req) begin
      state_reg <= ST_HOLD;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      a         <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
            a[0]    <= 1'b1;
            cnt_reg <= '0;
            idx_reg <= IDX_W'(1);
            if (NUM_CH == 1) begin
              state_reg <= ST_RUN;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg <= ST_STAGGER;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_STAGGER: begin
          if (cnt_reg == CNT_W'(STAGGER_CYCLES - 1)) begin
            a       <= a | rel_mask;
            cnt_reg <= '0;
            if (idx_reg == IDX_W'(NUM_CH - 1)) begin
              state_reg <= ST_RUN;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_RUN: begin
          a    <= '1;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          state_reg <= ST_HOLD;
          cnt_reg   <= '0;
          idx_reg   <= '0;
          a         <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
